// File: rtl/coriolis_fxp_scale_node.sv
// Streaming fixed-point scale node: out1 = sat(round(in1 * COEF / 2^FRAC)).
// LAT-deep valid/data pipeline with back-pressure and an in-flight beat counter.
module coriolis_fxp_scale_node #(
  parameter int unsigned            STREAMW = 34,
  parameter int unsigned            CW      = 18,
  parameter logic signed [CW-1:0]   COEF    = 18'sh0_4000,
  parameter int unsigned            FRAC    = 14,
  parameter int unsigned            LAT     = 4,
  parameter int unsigned            CNTW    = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ivalid_in1,
  input  logic signed [STREAMW-1:0] in1,
  output logic                      iready,
  output logic                      ovalid,
  output logic signed [STREAMW-1:0] out1,
  input  logic                      oready,
  output logic [CNTW-1:0]           count
);

  localparam int unsigned PW = STREAMW + CW;

  logic signed [PW-1:0]      prod_c;
  logic signed [PW-1:0]      rnd_c;
  logic signed [PW-1:0]      shr_c;
  logic signed [STREAMW-1:0] res_c;
  logic                      fits_c;
  logic                      accept_c;
  logic                      deliver_c;

  logic [LAT-1:0]            v;
  logic signed [STREAMW-1:0] d [LAT];

  // Full-precision product; PW bits always hold the extreme corner product.
  assign prod_c = PW'(in1) * PW'(COEF);

  if (FRAC == 0) begin : g_no_round
    assign rnd_c = prod_c;
  end else begin : g_round
    assign rnd_c = prod_c + (PW'(1) <<< (FRAC - 1));
  end

  assign shr_c = rnd_c >>> FRAC;

  // Result fits when every bit above the output sign bit matches it.
  assign fits_c = (shr_c[PW-1:STREAMW-1] == {(CW + 1){shr_c[PW-1]}});
  assign res_c  = fits_c ? shr_c[STREAMW-1:0]
                         : {shr_c[PW-1], {(STREAMW - 1){~shr_c[PW-1]}}};

  assign iready    = ~v[LAT-1] | oready;
  assign ovalid    = v[LAT-1];
  assign out1      = d[LAT-1];
  assign accept_c  = ivalid_in1 & iready;
  assign deliver_c = ovalid & oready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v     <= '0;
      count <= '0;
      for (int unsigned i = 0; i < LAT; i++) begin
        d[i] <= '0;
      end
    end else begin
      // Whole pipeline moves together; bubbles are carried, not squeezed out.
      if (iready) begin
        v[0] <= ivalid_in1;
        if (ivalid_in1) begin
          d[0] <= res_c;
        end
        for (int unsigned i = 1; i < LAT; i++) begin
          v[i] <= v[i-1];
          d[i] <= d[i-1];
        end
      end
      count <= count + CNTW'(accept_c) - CNTW'(deliver_c);
    end
  end

endmodule

// File: tb/tb_coriolis_fxp_scale_node.sv
// Directed bench for coriolis_fxp_scale_node at STREAMW=16, COEF=1.5 (Q8), LAT=4.
module tb_coriolis_fxp_scale_node;

  logic        clk;
  logic        rst;
  logic        ivalid_in1;
  logic [15:0] in1;
  logic        iready;
  logic        ovalid;
  logic [15:0] out1;
  logic        oready;
  logic [2:0]  count;

  int total = 0;
  int bad   = 0;

  coriolis_fxp_scale_node #(
    .STREAMW(16), .CW(16), .COEF(16'sh0180), .FRAC(8), .LAT(4), .CNTW(3)
  ) dut (
    .clk(clk), .rst(rst), .ivalid_in1(ivalid_in1), .in1(in1), .iready(iready),
    .ovalid(ovalid), .out1(out1), .oready(oready), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic next_slot();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    total++; if (ovalid !== 1'b0) begin bad++; $display("FAIL reset_ovalid: got %b want 0", ovalid); end
    total++; if (out1 !== 16'h0000) begin bad++; $display("FAIL reset_out1: got %h want 0000", out1); end
    total++; if (count !== 3'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", count); end
    total++; if (iready !== 1'b1) begin bad++; $display("FAIL reset_iready: got %b want 1", iready); end
  endtask

  // Single beat: checks latency, value and count 1 -> 0 on delivery.
  task automatic test_scale(input logic [15:0] x, input logic [15:0] exp, input string nm);
    oready     = 1'b1;
    ivalid_in1 = 1'b1;
    in1        = x;
    next_slot();
    ivalid_in1 = 1'b0;
    in1        = 'x;
    total++; if (count !== 3'd1) begin bad++; $display("FAIL %s_count_accept: got %0d want 1", nm, count); end
    for (int i = 0; i < 3; i++) begin
      total++; if (ovalid !== 1'b0) begin bad++; $display("FAIL %s_early_ovalid: got %b want 0 at stage %0d", nm, ovalid, i); end
      next_slot();
    end
    total++; if (ovalid !== 1'b1) begin bad++; $display("FAIL %s_ovalid: got %b want 1", nm, ovalid); end
    total++; if (out1 !== exp) begin bad++; $display("FAIL %s_out1: got %h want %h", nm, out1, exp); end
    total++; if (count !== 3'd1) begin bad++; $display("FAIL %s_count_full: got %0d want 1", nm, count); end
    next_slot();
    total++; if (ovalid !== 1'b0) begin bad++; $display("FAIL %s_ovalid_after: got %b want 0", nm, ovalid); end
    total++; if (count !== 3'd0) begin bad++; $display("FAIL %s_count_after: got %0d want 0", nm, count); end
  endtask

  // Stream 1..10 with oready low on cycles 6..10.
  task automatic test_backpressure();
    logic [15:0] exp_tab [10] = '{16'd2, 16'd3, 16'd5, 16'd6, 16'd8, 16'd9, 16'd11, 16'd12, 16'd14, 16'd15};
    logic [3:0]  mv   = 4'b0000;
    int          cm   = 0;
    int          peak = 0;
    int          sent = 0;
    int          got  = 0;
    logic        en_m;
    logic        acc_m;
    logic        del_m;
    for (int c = 1; c <= 60 && got < 10; c++) begin
      oready     = !(c >= 6 && c <= 10);
      ivalid_in1 = (sent < 10);
      in1        = (sent < 10) ? 16'(sent + 1) : 'x;
      #1;
      en_m  = !mv[3] || oready;
      acc_m = ivalid_in1 && en_m;
      del_m = mv[3] && oready;
      total++; if (iready !== en_m) begin bad++; $display("FAIL bp_iready: got %b want %b cycle %0d", iready, en_m, c); end
      total++; if (ovalid !== mv[3]) begin bad++; $display("FAIL bp_ovalid: got %b want %b cycle %0d", ovalid, mv[3], c); end
      total++; if (count !== 3'(cm)) begin bad++; $display("FAIL bp_count: got %0d want %0d cycle %0d", count, cm, c); end
      if (mv[3]) begin
        total++; if (out1 !== exp_tab[got]) begin bad++; $display("FAIL bp_out1: got %h want %h cycle %0d", out1, exp_tab[got], c); end
      end
      if (del_m) got++;
      if (acc_m) sent++;
      if (en_m) mv = {mv[2:0], acc_m};
      cm = cm + int'(acc_m) - int'(del_m);
      if (cm > peak) peak = cm;
      @(posedge clk);
      #1;
    end
    ivalid_in1 = 1'b0;
    oready     = 1'b1;
    total++; if (got != 10) begin bad++; $display("FAIL bp_delivered: got %0d want 10", got); end
    total++; if (peak != 4) begin bad++; $display("FAIL bp_peak: got %0d want 4", peak); end
  endtask

  // 32 back-to-back beats of 2n -> 3n.
  task automatic test_back_to_back();
    int run = 0;
    oready     = 1'b1;
    ivalid_in1 = 1'b1;
    in1        = 16'd0;
    for (int t = 0; t <= 36; t++) begin
      next_slot();
      if (t + 1 < 32) in1 = 16'(2 * (t + 1));
      else begin ivalid_in1 = 1'b0; in1 = 'x; end
      total++; if (ovalid !== (t >= 3 && t <= 34)) begin bad++; $display("FAIL b2b_ovalid: got %b at slot %0d", ovalid, t); end
      if (t >= 3 && t <= 34) begin
        total++; if (out1 !== 16'(3 * (t - 3))) begin bad++; $display("FAIL b2b_out1: got %h want %h slot %0d", out1, 16'(3 * (t - 3)), t); end
      end
      if (ovalid === 1'b1) run++;
    end
    total++; if (run != 32) begin bad++; $display("FAIL b2b_run: got %0d want 32", run); end
  endtask

  task automatic test_reset_midstream();
    oready     = 1'b1;
    ivalid_in1 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in1 = 16'(10 + i);
      next_slot();
    end
    ivalid_in1 = 1'b0;
    total++; if (count !== 3'd3) begin bad++; $display("FAIL rstmid_inflight: got %0d want 3", count); end
    #3;
    rst = 1'b1;
    #1;
    total++; if (ovalid !== 1'b0) begin bad++; $display("FAIL rstmid_ovalid: got %b want 0", ovalid); end
    total++; if (out1 !== 16'h0000) begin bad++; $display("FAIL rstmid_out1: got %h want 0000", out1); end
    total++; if (count !== 3'd0) begin bad++; $display("FAIL rstmid_count: got %0d want 0", count); end
    next_slot();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      next_slot();
      total++; if (ovalid !== 1'b0) begin bad++; $display("FAIL rstmid_post_ovalid: got %b want 0 cycle %0d", ovalid, i); end
      total++; if (count !== 3'd0) begin bad++; $display("FAIL rstmid_post_count: got %0d want 0 cycle %0d", count, i); end
    end
  endtask

  initial begin
    rst        = 1'b1;
    ivalid_in1 = 1'b0;
    in1        = 16'h0000;
    oready     = 1'b1;
    repeat (2) next_slot();
    test_reset();
    rst = 1'b0;
    next_slot();
    test_scale(16'h0100, 16'h0180, "basic");
    test_scale(16'h0001, 16'h0002, "round_up");
    test_scale(16'hFFFF, 16'hFFFF, "neg_one");
    test_scale(16'h0000, 16'h0000, "zero");
    test_scale(16'h7FFF, 16'h7FFF, "sat_pos");
    test_scale(16'h8000, 16'h8000, "sat_neg");
    test_backpressure();
    repeat (6) next_slot();
    test_back_to_back();
    test_reset_midstream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/coriolis_fxp_scale_node.md
Name: coriolis_fxp_scale_node

Overview:
- Parametrised leaf map node for the TyTra streaming datapath: out1 = round(in1 × COEF / 2^FRAC), saturated to STREAMW signed.
- Latency is configurable (LAT stages). The valid pipeline advances in lock-step with the data pipeline, and downstream stalls are handled correctly.
- Exposes in-flight beat count for the kernel controller.
- Sits between stream source and downstream map/reduce nodes, in place of fixed-latency FP-core wrappers where fixed-point is adequate.

Parameters:
- STREAMW, 34, data width of in1/out1, signed two's complement.
- CW, 18, width of coefficient, signed.
- COEF, 18'sh0_4000, scale coefficient, signed, CW bits.
- FRAC, 14, fractional bits of COEF; product arithmetic-shifted right by FRAC. Range 0..CW-1.
- LAT, 4, pipeline depth in stages. Legal range 1..16.
- CNTW, 5, width of count output; must satisfy 2^CNTW > LAT.

Ports:
- clk, input, 1, clock.
- rst, input, 1, asynchronous active-high reset.
- ivalid_in1, input, 1, input beat valid.
- in1, input, STREAMW, input operand, signed.
- iready, output, 1, node can accept a beat this cycle.
- ovalid, output, 1, out1 holds a valid result.
- out1, output, STREAMW, scaled, rounded, saturated result.
- oready, input, 1, downstream accepts out1 this cycle.
- count, output, CNTW, number of valid beats currently held in the pipeline (0..LAT).

Behaviour:
- Reset (async, active-high): all stage valid bits = 0, stage data = 0, ovalid = 0, out1 = 0, count = 0. Reset asserted mid-stream discards all in-flight beats; no output appears after rst deasserts until new beats are accepted.
- Pipeline:
  - LAT stages, each holds valid bit v[i] and data d[i]. Stage LAT-1 drives ovalid = v[LAT-1] and out1 = d[LAT-1].
  - Advance enable: en = ~v[LAT-1] | oready.
  - iready = en, combinational from oready and v[LAT-1].
- On a clock edge with en = 1:
  - v[0] <= ivalid_in1.
  - d[0] <= result(in1) when ivalid_in1 = 1, otherwise d[0] holds.
  - v[i] <= v[i-1] and d[i] <= d[i-1] for i = 1..LAT-1.
- With en = 0 every stage holds. out1 and ovalid are stable while ovalid & ~oready.
- Beat accounting:
  - Accept occurs when ivalid_in1 & iready. Deliver occurs when ovalid & oready.
  - Bubbles (v = 0) travel through the pipeline and are not collapsed.
- Latency: a beat accepted at edge k with en high on every following edge appears with ovalid = 1 after edge k+LAT-1. That is LAT cycles from in1 sampled to out1 usable.
- Throughput: 1 beat/cycle while oready = 1.
- count: registered. Each edge applies +1 on accept and -1 on deliver; simultaneous accept and deliver leaves count unchanged. count never exceeds LAT.
- Arithmetic:
  - p = in1 × COEF, full precision, STREAMW+CW bits, signed.
  - r = (p + 2^(FRAC-1)) >>> FRAC (arithmetic shift, round half up). For FRAC = 0, r = p.
  - Saturate r to [-2^(STREAMW-1), 2^(STREAMW-1)-1].
  - The multiply may be retimed across stages, but the observable result and latency must equal the above.
- Boundary cases:
  - Pipeline full with oready low: iready = 0. Input held by upstream is not consumed.
  - Pipeline full, oready rises: delivery and a new accept happen on the same edge.
  - X on in1 while ivalid_in1 = 0 must not propagate to out1 when ovalid = 1.

Test Plan (STREAMW=16, CW=16, COEF=16'sh0180 (1.5), FRAC=8, LAT=4, CNTW=3):
- Basic: oready = 1, send in1 = 0x0100 -> after 4 cycles ovalid = 1, out1 = 0x0180, count goes 1→0 on delivery.
- Rounding and sign:
  - in1 = 0x0001 -> out1 = 0x0002 (1.5 rounds up).
  - in1 = 0xFFFF -> out1 = 0xFFFF.
  - in1 = 0x0000 -> out1 = 0x0000.
- Saturation: in1 = 0x7FFF -> out1 = 0x7FFF; in1 = 0x8000 -> out1 = 0x8000.
- Back-pressure: stream in1 = 1..10 continuously with oready low on cycles 6-10.
  - Required response: outputs equal round(1.5·n) in order with no loss or duplicates.
  - out1 is stable while stalled; iready = 0 whenever count = 4 and oready = 0; count peaks at 4.
- Throughput: 32 back-to-back beats with oready = 1 -> 32 consecutive ovalid cycles starting 4 cycles after the first accept.
- Reset mid-stream: assert rst asynchronously with 3 beats in flight -> ovalid = 0, out1 = 0, count = 0 immediately. After release with no new input, no ovalid for 10 cycles.
